// File: rtl/rca_pkg.sv
// Shared defaults and checker state encoding for the rca adder and its on-line checker.
package rca_pkg;

    localparam int RCA_WIDTH = 4;
    localparam int RCA_CNT_W = 8;

    // 2'd3 is unused; the checker FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/rca_ref_model.sv
// Golden adder: full-width sum of two operands and a carry-in, no truncation.
module rca_ref_model #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   exp
);

    assign exp = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);

endmodule

// File: rtl/rca_checker.sv
// On-line checker for the rca adder: stages each vector, compares it against a golden sum,
// and keeps saturating statistics plus a snapshot of the first failing vector.
//
// state | meaning
// IDLE  | no vector checked since reset or clear
// PASS  | at least one vector checked, all matched
// FAIL  | at least one mismatch seen; first_* frozen until reset or clear
module rca_checker
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int CNT_W = RCA_CNT_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             chk_valid,
    input  logic [WIDTH-1:0] chk_in1,
    input  logic [WIDTH-1:0] chk_in2,
    input  logic             chk_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    input  logic             clear,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_in1,
    output logic [WIDTH-1:0] first_in2,
    output logic             first_cin,
    output logic [WIDTH:0]   first_exp,
    output logic [WIDTH:0]   first_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             stg_valid_q, stg_valid_d;
    logic [WIDTH-1:0] stg_in1_q, stg_in1_d;
    logic [WIDTH-1:0] stg_in2_q, stg_in2_d;
    logic             stg_cin_q, stg_cin_d;
    logic [WIDTH:0]   stg_got_q, stg_got_d;

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] first_in1_q, first_in1_d;
    logic [WIDTH-1:0] first_in2_q, first_in2_d;
    logic             first_cin_q, first_cin_d;
    logic [WIDTH:0]   first_exp_q, first_exp_d;
    logic [WIDTH:0]   first_got_q, first_got_d;

    logic [WIDTH:0]   exp_sum;
    logic             mismatch;

    rca_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a   (stg_in1_q),
        .b   (stg_in2_q),
        .cin (stg_cin_q),
        .exp (exp_sum)
    );

    assign mismatch = stg_valid_q && (exp_sum != stg_got_q);

    always_comb begin
        stg_valid_d = chk_valid & ~clear;
        stg_in1_d   = stg_in1_q;
        stg_in2_d   = stg_in2_q;
        stg_cin_d   = stg_cin_q;
        stg_got_d   = stg_got_q;
        // Operands are only loaded on valid so idle X inputs never enter the stage.
        if (chk_valid) begin
            stg_in1_d = chk_in1;
            stg_in2_d = chk_in2;
            stg_cin_d = chk_cin;
            stg_got_d = {dut_cout, dut_sum};
        end
    end

    always_comb begin
        state_d     = state_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        first_in1_d = first_in1_q;
        first_in2_d = first_in2_q;
        first_cin_d = first_cin_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;

        if (clear) begin
            state_d     = IDLE;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
            first_in1_d = '0;
            first_in2_d = '0;
            first_cin_d = 1'b0;
            first_exp_d = '0;
            first_got_d = '0;
        end else begin
            if (stg_valid_q) begin
                if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_W'(1);
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                IDLE, PASS: begin
                    if (mismatch) begin
                        state_d     = FAIL;
                        first_in1_d = stg_in1_q;
                        first_in2_d = stg_in2_q;
                        first_cin_d = stg_cin_q;
                        first_exp_d = exp_sum;
                        first_got_d = stg_got_q;
                    end else if (stg_valid_q) begin
                        state_d = PASS;
                    end
                end
                FAIL:    state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stg_valid_q <= 1'b0;
            stg_in1_q   <= '0;
            stg_in2_q   <= '0;
            stg_cin_q   <= 1'b0;
            stg_got_q   <= '0;
            state_q     <= IDLE;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            first_in1_q <= '0;
            first_in2_q <= '0;
            first_cin_q <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_in1_q   <= stg_in1_d;
            stg_in2_q   <= stg_in2_d;
            stg_cin_q   <= stg_cin_d;
            stg_got_q   <= stg_got_d;
            state_q     <= state_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            first_in1_q <= first_in1_d;
            first_in2_q <= first_in2_d;
            first_cin_q <= first_cin_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign chk_count = chk_cnt_q;
    assign err_count = err_cnt_q;
    assign err_pulse = err_pulse_q;
    assign err_flag  = (state_q == FAIL);
    assign first_in1 = first_in1_q;
    assign first_in2 = first_in2_q;
    assign first_cin = first_cin_q;
    assign first_exp = first_exp_q;
    assign first_got = first_got_q;

endmodule

// File: tb/tb_rca_checker.sv
// Directed bench for rca_checker: expected outputs are queued at stimulus time and
// retired two edges later, with every output compared after every edge.
module tb_rca_checker;

    logic       clock = 1'b0;
    logic       resetn;
    logic       chk_valid;
    logic [3:0] chk_in1, chk_in2, dut_sum;
    logic       chk_cin, dut_cout, clear;
    logic [7:0] chk_count, err_count;
    logic       err_pulse, err_flag;
    logic [3:0] first_in1, first_in2;
    logic       first_cin;
    logic [4:0] first_exp, first_got;

    always #5 clock = ~clock;

    rca_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .chk_valid (chk_valid),
        .chk_in1   (chk_in1),
        .chk_in2   (chk_in2),
        .chk_cin   (chk_cin),
        .dut_sum   (dut_sum),
        .dut_cout  (dut_cout),
        .clear     (clear),
        .chk_count (chk_count),
        .err_count (err_count),
        .err_pulse (err_pulse),
        .err_flag  (err_flag),
        .first_in1 (first_in1),
        .first_in2 (first_in2),
        .first_cin (first_cin),
        .first_exp (first_exp),
        .first_got (first_got)
    );

    typedef struct {
        int         due;
        logic [7:0] chk;
        logic [7:0] err;
        logic       pulse;
        logic       flag;
        logic [3:0] f1;
        logic [3:0] f2;
        logic       fc;
        logic [4:0] fe;
        logic [4:0] fg;
    } exp_t;

    exp_t q[$];
    exp_t m, cur, zero_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, expv);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("chk_count", 32'(chk_count), 32'(e.chk));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("err_pulse", 32'(err_pulse), 32'(e.pulse));
        chk("err_flag",  32'(err_flag),  32'(e.flag));
        chk("first_in1", 32'(first_in1), 32'(e.f1));
        chk("first_in2", 32'(first_in2), 32'(e.f2));
        chk("first_cin", 32'(first_cin), 32'(e.fc));
        chk("first_exp", 32'(first_exp), 32'(e.fe));
        chk("first_got", 32'(first_got), 32'(e.fg));
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [4:0] got,
                        input logic clr, input logic rstn);
        exp_t       n;
        logic [4:0] e5;
        logic       clr_now;
        resetn    = rstn;
        clear     = clr;
        chk_valid = v;
        if (v) begin
            chk_in1 = a; chk_in2 = b; chk_cin = c;
            {dut_cout, dut_sum} = got;
        end else begin
            chk_in1 = 'x; chk_in2 = 'x; chk_cin = 'x; dut_sum = 'x; dut_cout = 'x;
        end
        clr_now = !rstn || clr;
        if (clr_now) begin
            q.delete();
            m = zero_e;
        end else if (v) begin
            e5 = {1'b0, a} + {1'b0, b} + {4'b0, c};
            n = m;
            n.pulse = 1'b0;
            if (n.chk != 8'hFF) n.chk = n.chk + 8'd1;
            if (e5 != got) begin
                n.pulse = 1'b1;
                if (n.err != 8'hFF) n.err = n.err + 8'd1;
                if (!n.flag) begin
                    n.flag = 1'b1;
                    n.f1 = a; n.f2 = b; n.fc = c; n.fe = e5; n.fg = got;
                end
            end
            n.due = cyc + 2;
            m = n;
            q.push_back(n);
        end
        @(posedge clock);
        cyc++;
        #1;
        if (clr_now) cur = zero_e;
        else if (q.size() > 0 && q[0].due == cyc) cur = q.pop_front();
        else cur.pulse = 1'b0;
        check_all(cur);
    endtask

    task automatic vec(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] got);
        step(1'b1, a, b, c, got, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b0, 1'b1);
    endtask

    initial begin
        zero_e = '{default: '0};
        m      = zero_e;
        cur    = zero_e;

        // reset held two cycles while a vector is offered
        step(1'b1, 4'b1011, 4'b1101, 1'b0, 5'b11001, 1'b0, 1'b0);
        step(1'b1, 4'b1011, 4'b1101, 1'b0, 5'b11001, 1'b0, 1'b0);
        idle(2);

        vec(4'b0101, 4'b1010, 1'b1, 5'b10000);
        idle(2);
        chk("pass_chk_lit", 32'(chk_count), 32'd1);
        chk("pass_flag_lit", 32'(err_flag), 32'd0);

        vec(4'b1011, 4'b1101, 1'b0, 5'b11001);
        idle(2);
        chk("fail_exp_lit", 32'(first_exp), 32'h18);
        chk("fail_got_lit", 32'(first_got), 32'h19);
        vec(4'b0001, 4'b0001, 1'b0, 5'b00011);
        idle(2);
        chk("second_err_lit", 32'(err_count), 32'd2);
        chk("second_first_in1_lit", 32'(first_in1), 32'hB);

        step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b1, 1'b1);
        vec(4'b0011, 4'b0100, 1'b0, 5'b00111);
        vec(4'b1111, 4'b1111, 1'b1, 5'b01111);
        vec(4'b1000, 4'b1000, 1'b0, 5'b10000);
        vec(4'b0000, 4'b0000, 1'b1, 5'b00000);
        idle(2);
        chk("b2b_chk_lit", 32'(chk_count), 32'd4);
        chk("b2b_err_lit", 32'(err_count), 32'd2);

        step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            logic [3:0] a;
            a = 4'(i);
            vec(a, 4'h3, 1'b0, {1'b0, a} + 5'd4);
        end
        idle(2);
        chk("sat_chk_lit", 32'(chk_count), 32'd255);
        chk("sat_err_lit", 32'(err_count), 32'd255);

        step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b1, 1'b1);
        vec(4'b1011, 4'b1101, 1'b0, 5'b11001);
        step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b1, 1'b1);
        idle(2);
        chk("clr_mid_flag_lit", 32'(err_flag), 32'd0);

        vec(4'b1011, 4'b1101, 1'b0, 5'b11001);
        step(1'b0, 4'h0, 4'h0, 1'b0, 5'h0, 1'b0, 1'b0);
        idle(2);
        chk("rst_mid_chk_lit", 32'(chk_count), 32'd0);

        vec(4'b0110, 4'b0110, 1'b0, 5'b01100);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rca_checker.md
Name: rca_checker

Overview:
Synthesizable on-line checker that sits on the output side of the rca ripple-carry adder and verifies its results.
- Consumes each operand vector together with the rca result and compares the result against an internal golden sum.
- Keeps saturating pass and fail statistics and captures the first failing vector.
- Used in the lab bench and on-board so adder results are checked continuously instead of read off a waveform.

Parameters:
WIDTH, 4, operand width; must match the rca instance.
CNT_W, 8, width of the checked-vector and error counters.

Ports:
clock  in  1  rising-edge clock.
resetn  in  1  synchronous active-low reset.
chk_valid  in  1  a vector is presented this cycle.
chk_in1  in  WIDTH  operand A as driven into rca.
chk_in2  in  WIDTH  operand B as driven into rca.
chk_cin  in  1  carry-in as driven into rca.
dut_sum  in  WIDTH  rca sum output.
dut_cout  in  1  rca carry-out.
clear  in  1  synchronous statistics clear.
chk_count  out  CNT_W  vectors checked, saturating.
err_count  out  CNT_W  mismatches, saturating.
err_pulse  out  1  one-cycle pulse per mismatch.
err_flag  out  1  sticky: at least one mismatch since reset or clear.
first_in1  out  WIDTH  operand A of the first failing vector.
first_in2  out  WIDTH  operand B of the first failing vector.
first_cin  out  1  carry-in of the first failing vector.
first_exp  out  WIDTH+1  expected {cout,sum} of the first failing vector.
first_got  out  WIDTH+1  observed {cout,sum} of the first failing vector.

Behaviour:
- Reset (resetn=0 at a rising edge): every output is 0, the stage register is invalid, and the state is IDLE. Reset overrides clear and chk_valid.
- Stage 1: at an edge with chk_valid=1, the block registers in1, in2, cin and {dut_cout,dut_sum}, and sets stage_valid. With chk_valid=0, the inputs are ignored, may be X, and stage_valid is cleared.
- Stage 2: exp = in1 + in2 + cin, computed WIDTH+1 bits wide with no truncation. It is compared with the registered {cout,sum}. Counters and flags update at the next edge.
- Latency: a vector presented in cycle N updates the outputs after edge N+1, i.e. visible in cycle N+2.
- Throughput: 1 vector per cycle. Back-to-back valids require no bubbles.
- Every checked vector increments chk_count. On a mismatch, err_count also increments and err_pulse is high for exactly one cycle.
- Saturation: each counter holds at 2^CNT_W-1 and does not wrap. err_pulse still fires while err_count is saturated.
- State machine, with err_flag = (state==FAIL):
  - IDLE: no vector checked since reset or clear.
  - IDLE -> PASS on a matching vector.
  - IDLE or PASS -> FAIL on a mismatching vector. This transition captures the first_* registers.
  - FAIL holds until reset or clear. Later mismatches do not overwrite first_*.
- clear=1 at an edge:
  - Counters, first_* and err_pulse go to 0, and the state returns to IDLE.
  - The vector in the stage register is discarded and not counted.
  - A vector sampled at the same edge is also dropped.
- resetn low mid-stream behaves like clear and additionally overrides everything. The first valid vector after release is sampled at the edge after resetn returns high.

Decomposition:
- Shared package rca_pkg holds:
  - the WIDTH default;
  - the state encoding IDLE=2'd0, PASS=2'd1, FAIL=2'd2, with 2'd3 illegal and forced to IDLE;
  - the CNT_W default.
- One sub-module, rca_ref_model: a purely combinational golden adder with inputs a, b, cin and output exp[WIDTH:0]. It is reusable by other benches.

Test Plan:
- Reset: resetn=0 for 2 cycles with chk_valid=1 -> all outputs 0 and state IDLE.
- Pass vector: in1=4'b0101, in2=4'b1010, cin=1, sum=4'b0000, cout=1 -> after 2 edges, chk_count=1, err_count=0, err_flag=0, no err_pulse.
- Fail vector, followed by a second different mismatch:
  - First: in1=4'b1011, in2=4'b1101, cin=0, sum=4'b1001, cout=1 -> err_pulse for 1 cycle, err_count=1, err_flag=1, first_exp=5'b11000, first_got=5'b11001.
  - Second mismatch -> err_count=2 and first_* unchanged.
- Back-to-back: 4 consecutive valid cycles alternating pass and fail -> chk_count=4, err_count=2, err_pulse high on 2 non-adjacent cycles.
- Saturation: 300 consecutive mismatching vectors with CNT_W=8 -> chk_count=255, err_count=255, both held, err_pulse still high per mismatch.
- Clear and reset mid-stream:
  - clear asserted the cycle after a failing vector is sampled -> counters 0, state IDLE, err_flag 0, no err_pulse.
  - The same sequence with resetn instead of clear -> identical result.
